// File: rtl/async_fifo_wr_arbiter.sv
// async_fifo_wr_arbiter
// Round-robin arbiter that shares the single write port of an async FIFO
// between NREQ requesters in the write-clock domain. Each grant lasts until
// MAX_BURST words have moved or the grantee drops valid. After every grant
// there is one idle cycle. No write is issued while the FIFO reports full.
//
// Ports
//   wr_clk     write clock, rising edge
//   awresetn   synchronous active-low reset
//   req_valid  per-requester word valid
//   req_data   packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  per-requester accept (transfer on valid & ready)
//   wr_full    FIFO full flag
//   wren       FIFO write enable
//   data_in    FIFO write data
//   grant_id   current grantee, meaningful while busy=1
//   busy       high while a grant is held
//
// State table
//   S_IDLE  | no grant; pick next requester upward from rr_ptr
//   S_GRANT | grant_id owns the FIFO write port
module async_fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      wr_clk,
  input  logic                      awresetn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      wr_full,
  output logic                      wren,
  output logic [WIDTH-1:0]          data_in,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] TOP  = IW'(NREQ - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            busy_q, busy_d;

  logic [WIDTH-1:0] words [NREQ];
  logic [IW-1:0]    pick;
  logic             pick_found;
  logic             cur_valid;
  int               slot;

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Search upward from rr_ptr; the wrap is done on an integer so a
  // non-power-of-two NREQ never produces an out-of-range index.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    slot       = 0;
    for (int i = 0; i < NREQ; i++) begin
      slot = int'(rr_ptr_q) + i;
      if (slot >= NREQ) slot = slot - NREQ;
      if (!pick_found && req_valid[IW'(slot)]) begin
        pick_found = 1'b1;
        pick       = IW'(slot);
      end
    end
  end

  // Transfer path is gated by awresetn so a reset cycle never writes,
  // even while the state register still holds S_GRANT.
  always_comb begin
    cur_valid = req_valid[grant_q];
    req_ready = '0;
    wren      = 1'b0;
    data_in   = '0;
    if (state_q == S_GRANT && awresetn) begin
      req_ready[grant_q] = ~wr_full;
      wren               = cur_valid & ~wr_full;
      data_in            = words[grant_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = S_GRANT;
          busy_d      = 1'b1;
        end
      end
      S_GRANT: begin
        if (wren) burst_cnt_d = burst_cnt_q + 1'b1;
        // A full-stall with valid held is not a release.
        if (!cur_valid || (wren && burst_cnt_q == LAST)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = (grant_q == TOP) ? '0 : grant_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (!awresetn) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
module tb_async_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int FDEPTH    = 16;

  logic                  wr_clk = 1'b0;
  logic                  awresetn;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wr_full;
  logic                  wren;
  logic [WIDTH-1:0]      data_in;
  logic [1:0]            grant_id;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]      src_q [NREQ][$];
  logic [7:0]      fifo_q[$];
  logic [NREQ-1:0] en;
  logic            force_full;
  int              tx_seq [NREQ];
  int              rx_seq [NREQ];
  int              rx_cnt [NREQ];
  int              snap   [NREQ];
  int              cyc = 0;
  int              n_wren = 0;
  int              gq[$];
  int              bq[$];
  logic            prev_busy = 1'b0;
  bit              started = 1'b0;

  // reference: current grantee (-1 when idle), words left in its quota
  int m_grant = -1;
  int m_ptr   = 0;
  int m_left  = 0;

  async_fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .wr_clk    (wr_clk),
    .awresetn  (awresetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_full   (wr_full),
    .wren      (wren),
    .data_in   (data_in),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && (src_q[i].size() > 0);
      req_data[i*WIDTH +: WIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
    wr_full = force_full || (fifo_q.size() >= FDEPTH);
  endtask

  task automatic push(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      src_q[i].push_back({2'(i), 6'(tx_seq[i])});
      tx_seq[i]++;
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    #2;
  endtask

  function automatic bit is_idle(input bit need_empty);
    bit r;
    r = (busy == 1'b0);
    for (int i = 0; i < NREQ; i++)
      if (en[i] && src_q[i].size() > 0) r = 1'b0;
    if (need_empty && fifo_q.size() > 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input string name, input int budget, input bit need_empty);
    int k;
    k = 0;
    while (k < budget && !is_idle(need_empty)) begin
      step();
      k++;
    end
    checks++;
    if (k >= budget) begin
      failures++;
      $display("FAIL timeout_%s actual=%0d cycles required<%0d", name, k, budget);
    end
  endtask

  task automatic wait_wren(input int n);
    int k;
    k = 0;
    while (n_wren < n && k < 100) begin
      step();
      k++;
    end
    chk("wait_wren_count", n_wren, n);
  endtask

  task automatic do_reset();
    awresetn = 1'b0;
    step();
    awresetn = 1'b1;
    gq.delete();
    bq.delete();
    n_wren = 0;
  endtask

  // Stimulus side: requester queues, FIFO with half-rate drain
  always @(posedge wr_clk) begin
    logic [7:0] b;
    logic [1:0] id;
    cyc++;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) src_q[i].delete(0);
    if (wren) fifo_q.push_back(data_in);
    if ((cyc % 2) == 0 && fifo_q.size() > 0) begin
      b  = fifo_q.pop_front();
      id = b[7:6];
      chk("fifo_order", {26'd0, b[5:0]}, {26'd0, 6'(rx_seq[id])});
      rx_seq[id]++;
      rx_cnt[id]++;
    end
    #1;
    drive();
  end

  // Reference model update
  always @(posedge wr_clk) begin
    logic [1:0] gi;
    logic       v;
    gi = 2'(m_grant);
    v  = (m_grant >= 0) ? req_valid[gi] : 1'b0;
    if (!awresetn) begin
      m_grant = -1;
      m_ptr   = 0;
    end else if (m_grant < 0) begin
      for (int k = 0; k < NREQ; k++)
        if (m_grant < 0 && req_valid[2'((m_ptr + k) % NREQ)]) begin
          m_grant = (m_ptr + k) % NREQ;
          m_left  = MAX_BURST;
        end
    end else if (!v) begin
      m_ptr   = (m_grant + 1) % NREQ;
      m_grant = -1;
    end else if (!wr_full) begin
      m_left--;
      if (m_left == 0) begin
        m_ptr   = (m_grant + 1) % NREQ;
        m_grant = -1;
      end
    end
    started = 1'b1;
  end

  // Compare process
  always @(negedge wr_clk) begin
    logic            e_wren;
    logic [NREQ-1:0] e_ready;
    logic [7:0]      e_data;
    logic [1:0]      gi;
    if (started) begin
      e_wren  = 1'b0;
      e_ready = '0;
      e_data  = 8'h00;
      gi      = 2'(m_grant);
      if (awresetn && m_grant >= 0) begin
        e_wren  = req_valid[gi] && !wr_full;
        e_ready = wr_full ? '0 : (NREQ'(1) << m_grant);
        e_data  = 8'(req_data >> (m_grant * WIDTH));
      end
      chk("wren", {31'd0, wren}, {31'd0, e_wren});
      chk("req_ready", {28'd0, req_ready}, {28'd0, e_ready});
      chk("data_in", {24'd0, data_in}, {24'd0, e_data});
      chk("busy", {31'd0, busy}, {31'd0, m_grant >= 0});
      if (m_grant >= 0) chk("grant_id", {30'd0, grant_id}, 32'(m_grant));
      if (busy === 1'b1 && prev_busy !== 1'b1) begin
        gq.push_back(int'(grant_id));
        bq.push_back(0);
      end
      if (wren === 1'b1) begin
        n_wren++;
        if (bq.size() > 0) bq[bq.size()-1]++;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    awresetn   = 1'b0;
    en         = '1;
    force_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      tx_seq[i] = 0;
      rx_seq[i] = 0;
      rx_cnt[i] = 0;
    end
    for (int i = 0; i < NREQ; i++) push(i, 2);
    drive();

    // reset held with all requesters valid
    repeat (3) begin
      step();
      #1;
      chk("rst_wren", {31'd0, wren}, 32'd0);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    awresetn = 1'b1;
    gq.delete();
    bq.delete();
    wait_idle("reset", 200, 1'b0);
    chk("rst_first_grant", (gq.size() > 0) ? gq[0] : -1, 0);

    // single requester, 10 words
    do_reset();
    en = 4'b0100;
    push(2, 10);
    wait_idle("single", 200, 1'b0);
    chk("single_wren_total", n_wren, 10);
    chk("single_grants", gq.size(), 3);
    chk("single_b0", (bq.size() > 0) ? bq[0] : -1, 4);
    chk("single_b1", (bq.size() > 1) ? bq[1] : -1, 4);
    chk("single_b2", (bq.size() > 2) ? bq[2] : -1, 2);
    chk("single_gid", (gq.size() > 0) ? gq[0] : -1, 2);

    // all valid: order 0,1,2,3,0 with 4 words each
    do_reset();
    en = '1;
    for (int i = 0; i < NREQ; i++) push(i, 8);
    wait_idle("all", 400, 1'b0);
    chk("all_grants", gq.size(), 8);
    for (int k = 0; k < 5; k++)
      chk("all_order", (gq.size() > k) ? gq[k] : -1, k % NREQ);
    for (int k = 0; k < bq.size(); k++)
      chk("all_burst", bq[k], MAX_BURST);

    // back-pressure after word 2
    do_reset();
    en = 4'b0010;
    push(1, 4);
    wait_wren(2);
    force_full = 1'b1;
    wr_full    = 1'b1;
    repeat (5) begin
      #1;
      chk("bp_wren", {31'd0, wren}, 32'd0);
      chk("bp_ready1", {31'd0, req_ready[1]}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      step();
    end
    force_full = 1'b0;
    drive();
    chk("bp_frozen", n_wren, 2);
    wait_idle("bp", 200, 1'b0);
    chk("bp_total", n_wren, 4);
    chk("bp_grants", gq.size(), 1);
    chk("bp_burst", (bq.size() > 0) ? bq[0] : -1, 4);

    // early drop by requester 0, requester 3 next
    do_reset();
    en = 4'b1001;
    push(0, 2);
    push(3, 4);
    wait_idle("drop", 200, 1'b0);
    chk("drop_g0", (gq.size() > 0) ? gq[0] : -1, 0);
    chk("drop_g1", (gq.size() > 1) ? gq[1] : -1, 3);
    chk("drop_b0", (bq.size() > 0) ? bq[0] : -1, 2);

    // reset during requester 2's third word
    do_reset();
    en = 4'b0100;
    push(2, 6);
    wait_wren(2);
    awresetn = 1'b0;
    en[0]    = 1'b1;
    push(0, 2);
    #1;
    chk("mr_wren", {31'd0, wren}, 32'd0);
    step();
    awresetn = 1'b1;
    gq.delete();
    bq.delete();
    wait_idle("midreset", 200, 1'b0);
    chk("mr_first_grant", (gq.size() > 0) ? gq[0] : -1, 0);
    chk("mr_second_grant", (gq.size() > 1) ? gq[1] : -1, 2);

    // randomized traffic, back-pressure and occasional reset
    for (int c = 0; c < 800; c++) begin
      en         = NREQ'($urandom);
      force_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, NREQ - 1);
        if (src_q[r].size() < 8) push(r, $urandom_range(1, 3));
      end
      awresetn = ($urandom_range(0, 99) != 0);
      step();
    end
    awresetn   = 1'b1;
    en         = '1;
    force_full = 1'b0;
    wait_idle("random", 3000, 1'b1);

    // end-to-end: 16 tagged bytes per requester
    for (int i = 0; i < NREQ; i++) snap[i] = rx_cnt[i];
    for (int i = 0; i < NREQ; i++) push(i, 16);
    wait_idle("e2e", 3000, 1'b1);
    for (int i = 0; i < NREQ; i++)
      chk("e2e_count", rx_cnt[i] - snap[i], 16);
    for (int i = 0; i < NREQ; i++)
      chk("e2e_seq", rx_seq[i], tx_seq[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
- Write-side arbiter that shares the single write port of async_fifo (WIDTH/POINTER instance) between NREQ requesters, all in the wr_clk domain.
- Round-robin grant with a bounded burst per grant, so one requester cannot starve the others.
- Drives wren/data_in into the FIFO and honours wr_full so that no write is issued while the FIFO is full.

Parameters:
- WIDTH, 8, data word width; equals the FIFO WIDTH.
- NREQ, 4, number of requesters (2..16).
- MAX_BURST, 4, maximum words accepted per grant before rotation (1..255).

Ports:
- wr_clk  input  1  write clock, rising edge.
- awresetn  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  per-requester word valid.
- req_data  input  NREQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  per-requester accept; a word transfers when valid&ready.
- wr_full  input  1  FIFO full flag from async_fifo.
- wren  output  1  FIFO write enable.
- data_in  output  WIDTH  FIFO write data.
- grant_id  output  $clog2(NREQ)  index of the current grantee; valid while busy=1.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (awresetn=0 at a wr_clk edge): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0. req_ready=0, wren=0 and data_in=0 combinationally while in IDLE.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, pick the first set index searching upward from rr_ptr with modulo-NREQ wrap.
  - Register that index as grant_id, clear burst_cnt, go to GRANT.
  - No transfer occurs in IDLE.
- GRANT transfer conditions (combinational):
  - req_ready[g] = ~wr_full for g = grant_id; all other ready bits are 0.
  - wren = req_valid[g] & ~wr_full.
  - data_in = req_data slice g.
  - wren is never 1 while wr_full=1.
- Each cycle with wren=1 increments burst_cnt.
- GRANT release, at the clock edge, when either:
  - (a) the transfer that makes burst_cnt reach MAX_BURST occurs, or
  - (b) req_valid[g]=0 in that cycle (no transfer).
  - On release: rr_ptr = (g+1) mod NREQ, state=IDLE.
  - This gives one bubble cycle between grants.
- wr_full in GRANT:
  - Stall with the grant held and burst_cnt frozen.
  - A stall cycle with req_valid[g]=1 does not count as a release.
  - The requester must hold valid/data stable while not ready.
- Latency: valid rises in IDLE at cycle t -> first write at cycle t+1 if not full.
- Fairness: with all requesters continuously valid and the FIFO never full, each gets MAX_BURST words per round in order g, g+1, ... Round length = NREQ*(MAX_BURST+1) cycles.
- Requesters dropping valid mid-burst: rotation proceeds as above and the remaining count is forfeited.
- NREQ not a power of two: wrap uses modulo NREQ, never an out-of-range index.
- Reset mid-burst: next edge returns to IDLE, rr_ptr=0 and wren=0 immediately. Partially sent bursts are not resumed.
- burst_cnt is wide enough for MAX_BURST and never wraps.

Test Plan:
- Reset: awresetn low for 3 cycles with all req_valid=1 -> wren=0, req_ready=0, busy=0 throughout; after release the first grant_id is 0.
- Single requester: req_valid=4'b0100, 10 words, FIFO empty -> grant_id=2.
  - Bursts of 4, 4, 2 words, each followed by one IDLE cycle.
  - Words appear on data_in in order; total 10 wren pulses.
- All valid, MAX_BURST=4 -> grant order 0,1,2,3,0; 4 words each; no requester gets a 5th word in a grant; rr_ptr wraps 3->0.
- Full back-pressure: requester 1 granted, wr_full asserted for 5 cycles after word 2.
  - wren=0 and req_ready[1]=0 during the stall; grant is held.
  - Words 3-4 are written after wr_full drops, then release.
- Early drop: requester 0 sends 2 words then deasserts valid while 3 is also valid -> release, IDLE bubble, grant_id=3 next (not 1 if 1 is idle).
- Mid-burst reset: reset pulsed during requester 2's 3rd word -> wren=0 at the reset cycle; after release the next grant starts from index 0.
- End-to-end: 4 requesters each push 16 tagged bytes through the arbiter into async_fifo (POINTER=4).
  - The read side drains at half rate; all 64 bytes are received with no loss or duplication.
  - Per-requester order is preserved.
